// File: rtl/led_pkg.sv
// led_pkg: shared types and constants for the LED arbiter.
//   - LED_W                : width of the LED bank
//   - OWN_NONE/OWN_PS/OWN_HW : owner encodings reported on o_owner
//   - state_t              : arbiter FSM states (encoded to match the owner codes)
//   - owner_of()           : maps an FSM state to its owner code
package led_pkg;

  localparam int LED_W = 8;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_PS   = 2'd1;
  localparam logic [1:0] OWN_HW   = 2'd2;

  // State codes equal the owner codes so o_owner is a direct decode.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN_PS = 2'd1,
    ST_OWN_HW = 2'd2
  } state_t;

  function automatic logic [1:0] owner_of(input state_t s);
    case (s)
      ST_OWN_PS: owner_of = OWN_PS;
      ST_OWN_HW: owner_of = OWN_HW;
      default:   owner_of = OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/led_arbiter_ctrl_blink_timer.sv
// led_blink_timer: free-running blink prescaler.
//   i_clk   : system clock
//   i_rst   : synchronous reset, active-high (counter and phase to 0)
//   o_phase : blink phase; toggles each time the counter wraps from
//             BLINK_DIV-1 back to 0, so each phase lasts BLINK_DIV cycles.
module led_blink_timer #(
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_phase
);

  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == CNT_MAX) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/led_arbiter_ctrl.sv
// led_arbiter_ctrl: arbitrates the board LED bank between PS software and
// PL hardware status logic, applies a per-bit blink mask and drives the
// registered LED pins.
//   i_clk, i_rst                  : clock, synchronous active-high reset
//   i_ps_req/i_ps_led/i_ps_blink  : PS request, LED value, blink enables
//   o_ps_gnt                      : PS owns the LEDs
//   i_hw_req/i_hw_led/i_hw_blink  : HW request, LED value, blink enables
//   o_hw_gnt                      : HW owns the LEDs
//   o_LED                         : LED pins (one cycle after owner inputs)
//   o_owner                       : 0 none, 1 PS, 2 HW (exposes FSM state)
//   o_blink_phase                 : current blink phase
// Handshake: a requester holds i_x_req high for as long as it wants the
// LEDs; o_x_gnt is high in every cycle it owns them, and its LED value is
// shown on o_LED one cycle after being sampled under that grant. Dropping
// i_x_req releases ownership at the next edge.
module led_arbiter_ctrl
  import led_pkg::*;
#(
  parameter int BLINK_DIV   = 50_000_000,
  parameter int HOLD_CYCLES = 1000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ps_req,
  input  logic [LED_W-1:0] i_ps_led,
  input  logic [LED_W-1:0] i_ps_blink,
  output logic             o_ps_gnt,
  input  logic             i_hw_req,
  input  logic [LED_W-1:0] i_hw_led,
  input  logic [LED_W-1:0] i_hw_blink,
  output logic             o_hw_gnt,
  output logic [LED_W-1:0] o_LED,
  output logic [1:0]       o_owner,
  output logic             o_blink_phase
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

  state_t             r_state;
  state_t             w_next;
  logic [HOLD_W-1:0]  r_hold;
  logic [1:0]         r_last_owner;
  logic               r_ps_gnt;
  logic               r_hw_gnt;
  logic [1:0]         r_owner;
  logic [LED_W-1:0]   r_led;
  logic [LED_W-1:0]   w_led_next;
  logic               w_phase;
  logic               w_hold_done;

  led_blink_timer #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .o_phase (w_phase)
  );

  assign w_hold_done = (r_hold == HOLD_MAX);

  // Next-state: a release by the owner hands straight over to a waiting
  // requester; pre-emption only once the hold time has been served.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_ps_req && i_hw_req)
          w_next = (r_last_owner == OWN_PS) ? ST_OWN_HW : ST_OWN_PS;
        else if (i_ps_req)
          w_next = ST_OWN_PS;
        else if (i_hw_req)
          w_next = ST_OWN_HW;
      end
      ST_OWN_PS: begin
        if (!i_ps_req)
          w_next = i_hw_req ? ST_OWN_HW : ST_IDLE;
        else if (i_hw_req && w_hold_done)
          w_next = ST_OWN_HW;
      end
      ST_OWN_HW: begin
        if (!i_hw_req)
          w_next = i_ps_req ? ST_OWN_PS : ST_IDLE;
        else if (i_ps_req && w_hold_done)
          w_next = ST_OWN_PS;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // LED data from the current owner; IDLE keeps the last value on the pins.
  always_comb begin
    w_led_next = r_led;
    case (r_state)
      ST_OWN_PS: w_led_next = i_ps_led & (~i_ps_blink | {LED_W{w_phase}});
      ST_OWN_HW: w_led_next = i_hw_led & (~i_hw_blink | {LED_W{w_phase}});
      default:   w_led_next = r_led;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_hold       <= '0;
      r_last_owner <= OWN_HW;
      r_ps_gnt     <= 1'b0;
      r_hw_gnt     <= 1'b0;
      r_owner      <= OWN_NONE;
      r_led        <= '0;
    end else begin
      r_state  <= w_next;
      r_ps_gnt <= (w_next == ST_OWN_PS);
      r_hw_gnt <= (w_next == ST_OWN_HW);
      r_owner  <= owner_of(w_next);
      r_led    <= w_led_next;
      if (w_next != r_state) begin
        r_hold <= '0;
        if (w_next != ST_IDLE)
          r_last_owner <= owner_of(w_next);
      end else if (r_state != ST_IDLE && !w_hold_done) begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end

  assign o_ps_gnt      = r_ps_gnt;
  assign o_hw_gnt      = r_hw_gnt;
  assign o_owner       = r_owner;
  assign o_LED         = r_led;
  assign o_blink_phase = w_phase;

endmodule

// File: tb/tb_led_arbiter_ctrl.sv
module tb_led_arbiter_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_ps_req, i_hw_req;
  logic [7:0] i_ps_led, i_ps_blink, i_hw_led, i_hw_blink;
  logic       o_ps_gnt, o_hw_gnt, o_blink_phase;
  logic [7:0] o_LED;
  logic [1:0] o_owner;

  int n_cmp = 0;
  int n_err = 0;

  // Blink phase model
  int   ph_cnt = 0;
  logic ph = 1'b0;
  logic ph_prev = 1'b0;

  typedef struct {
    logic       rst;
    logic       ps_req;
    logic [7:0] ps_led;
    logic       hw_req;
    logic [7:0] hw_led;
    logic [1:0] exp_owner;
    logic [7:0] exp_led;
  } vec_t;

  vec_t vecs[16];

  led_arbiter_ctrl #(.BLINK_DIV(4), .HOLD_CYCLES(3)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_ps_req      (i_ps_req),
    .i_ps_led      (i_ps_led),
    .i_ps_blink    (i_ps_blink),
    .o_ps_gnt      (o_ps_gnt),
    .i_hw_req      (i_hw_req),
    .i_hw_led      (i_hw_led),
    .i_hw_blink    (i_hw_blink),
    .o_hw_gnt      (o_hw_gnt),
    .o_LED         (o_LED),
    .o_owner       (o_owner),
    .o_blink_phase (o_blink_phase)
  );

  // Clock / reset block
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge; the phase model advances on the same edge, then
  // outputs are sampled 1ns later.
  task automatic step();
    @(posedge i_clk);
    ph_prev = ph;
    if (i_rst) begin
      ph_cnt = 0;
      ph = 1'b0;
    end else if (ph_cnt == 3) begin
      ph_cnt = 0;
      ph = ~ph;
    end else begin
      ph_cnt++;
    end
    #1;
  endtask

  task automatic check_owner(input string name, input logic [1:0] exp);
    check({name, "_owner"}, 32'(o_owner), 32'(exp));
    check({name, "_ps_gnt"}, 32'(o_ps_gnt), 32'(exp == 2'd1));
    check({name, "_hw_gnt"}, 32'(o_hw_gnt), 32'(exp == 2'd2));
  endtask

  task automatic drive(input logic rst, input logic ps, input logic [7:0] psl,
                       input logic hw, input logic [7:0] hwl);
    i_rst = rst; i_ps_req = ps; i_ps_led = psl; i_hw_req = hw; i_hw_led = hwl;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    i_ps_blink = 8'h00; i_hw_blink = 8'h00;
    step();
    i_rst = 1'b0;
  endtask

  initial begin
    int edges;
    // Table: each row is inputs for one edge and the expected state after it.
    //           rst   ps    psl    hw    hwl    owner  led
    vecs[0]  = '{1'b1, 1'b1, 8'h3C, 1'b1, 8'hC3, 2'd0, 8'h00}; // reset, all reqs high
    vecs[1]  = '{1'b1, 1'b1, 8'h3C, 1'b1, 8'hC3, 2'd0, 8'h00};
    vecs[2]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 8'hC3, 2'd1, 8'h00}; // tie -> PS first
    vecs[3]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 8'hC3, 2'd1, 8'h3C};
    vecs[4]  = '{1'b0, 1'b1, 8'h5A, 1'b0, 8'hC3, 2'd1, 8'h5A}; // one-cycle latency
    vecs[5]  = '{1'b0, 1'b0, 8'h5A, 1'b1, 8'h96, 2'd2, 8'h5A}; // direct hand-over
    vecs[6]  = '{1'b0, 1'b0, 8'h5A, 1'b1, 8'h96, 2'd2, 8'h96};
    vecs[7]  = '{1'b0, 1'b0, 8'h5A, 1'b1, 8'hA5, 2'd2, 8'hA5};
    vecs[8]  = '{1'b0, 1'b0, 8'h5A, 1'b0, 8'hA5, 2'd0, 8'hA5}; // release -> IDLE
    vecs[9]  = '{1'b0, 1'b0, 8'h5A, 1'b0, 8'h00, 2'd0, 8'hA5}; // IDLE holds LEDs
    vecs[10] = '{1'b0, 1'b0, 8'h5A, 1'b0, 8'h00, 2'd0, 8'hA5};
    vecs[11] = '{1'b0, 1'b0, 8'h5A, 1'b1, 8'h11, 2'd2, 8'hA5};
    vecs[12] = '{1'b0, 1'b0, 8'h5A, 1'b1, 8'h11, 2'd2, 8'h11}; // hold_cnt now 1
    vecs[13] = '{1'b1, 1'b1, 8'h22, 1'b1, 8'h11, 2'd0, 8'h00}; // mid-op reset
    vecs[14] = '{1'b0, 1'b1, 8'h22, 1'b0, 8'h11, 2'd1, 8'h00};
    vecs[15] = '{1'b0, 1'b1, 8'h22, 1'b0, 8'h11, 2'd1, 8'h22};

    i_ps_blink = 8'h00; i_hw_blink = 8'h00;
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].ps_req, vecs[i].ps_led, vecs[i].hw_req, vecs[i].hw_led);
      step();
      check_owner($sformatf("vec%0d", i), vecs[i].exp_owner);
      check($sformatf("vec%0d_led", i), 32'(o_LED), 32'(vecs[i].exp_led));
      check($sformatf("vec%0d_phase", i), 32'(o_blink_phase), 32'(ph));
    end

    // Blink: PS owns with FF / mask 0F; pins track the phase one cycle late.
    do_reset();
    drive(1'b0, 1'b1, 8'hFF, 1'b0, 8'h00);
    i_ps_blink = 8'h0F;
    step();
    check_owner("blink_grant", 2'd1);
    for (int i = 0; i < 16; i++) begin
      step();
      check($sformatf("blink%0d_led", i), 32'(o_LED), ph_prev ? 32'hFF : 32'hF0);
      check($sformatf("blink%0d_phase", i), 32'(o_blink_phase), 32'(ph));
    end

    // Round-robin with hold: HW raises req as PS is granted.
    do_reset();
    drive(1'b0, 1'b1, 8'h0F, 1'b0, 8'hF0);
    step();
    check_owner("rr_ps_first", 2'd1);
    i_hw_req = 1'b1;
    edges = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (o_hw_gnt) begin edges = n; break; end
    end
    check("rr_hw_edges", 32'(edges), 32'd3);
    check_owner("rr_hw_owns", 2'd2);
    edges = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (o_ps_gnt) begin edges = n; break; end
    end
    check("rr_ps_edges", 32'(edges), 32'd3);
    check_owner("rr_ps_owns", 2'd1);
    step();
    check("rr_led", 32'(o_LED), 32'h0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
